// File: rtl/subtree_child_sequencer.sv
// -----------------------------------------------------------------------------
// subtree_child_sequencer
//
// Runs the NUM_CHILD leaf children of one subtree node strictly one at a time,
// in ascending index order, skipping any child whose bit is set in the mask
// captured when the run starts. Each selected child gets a one-cycle start
// strobe; the sequencer then waits for that child's done strobe before moving
// on. A one-cycle done_o pulse tells the parent node that the run is finished.
//
// Optional feature (compile-time macro SCHED_TIMEOUT_EN):
//   A per-child WAIT counter aborts the run after TIMEOUT_CYCLES silent
//   cycles, raises the sticky err_o and still pulses done_o. Without the macro
//   there is no counter, WAIT lasts until the done arrives and err_o is 0.
//
// Ports
//   clk            in   1          rising-edge clock
//   rst            in   1          synchronous, active-high reset
//   start_i        in   1          run request, only looked at in IDLE
//   skip_mask_i    in   NUM_CHILD  1 = skip that child; captured on accept
//   child_start_o  out  NUM_CHILD  one-hot, one-cycle start strobe
//   child_done_i   in   NUM_CHILD  per-child completion strobe
//   cur_idx_o      out  IDX_W      index of the active (or last) child
//   busy_o         out  1          run in progress (ISSUE/WAIT)
//   done_o         out  1          one-cycle run-finished pulse
//   err_o          out  1          sticky timeout flag
// -----------------------------------------------------------------------------
module subtree_child_sequencer #(
    parameter int NUM_CHILD      = 5,
    parameter int IDX_W          = $clog2(NUM_CHILD),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [NUM_CHILD-1:0] skip_mask_i,
    output logic [NUM_CHILD-1:0] child_start_o,
    input  logic [NUM_CHILD-1:0] child_done_i,
    output logic [IDX_W-1:0]     cur_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    if (NUM_CHILD < 2 || NUM_CHILD > 16) begin : g_bad_num_child
        $error("NUM_CHILD must lie in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CHILD-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W:0]       scan;          // {found, index}
    logic                 done_active;
    logic                 timeout_hit;

    // Lowest unmasked index >= from. The scan stops at NUM_CHILD-1 and never
    // wraps, so asking from NUM_CHILD simply reports "none found".
    function automatic logic [IDX_W:0] find_next(input logic [NUM_CHILD-1:0] mask,
                                                 input int                   from);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_CHILD - 1; i >= 0; i--) begin
            if (i >= from && !mask[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    // Only the active child's done counts; strays from other children are ignored.
    assign done_active = child_done_i[idx_q];

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q is 0 in the first WAIT cycle, so the limit is reached in the
    // TIMEOUT_CYCLES-th WAIT cycle.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_IDLE && start_i) begin
            err_d = 1'b0;
        end
        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
            // A done in the same cycle as the timeout wins: no error.
            if (!done_active && timeout_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        scan    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mask_d = skip_mask_i;
                    scan   = find_next(skip_mask_i, 0);
                    if (scan[IDX_W]) begin
                        idx_d   = scan[IDX_W-1:0];
                        state_d = S_ISSUE;
                    end else begin
                        // Everything skipped: cur_idx_o keeps its old value.
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_active) begin
                    scan = find_next(mask_q, int'(idx_q) + 1);
                    if (scan[IDX_W]) begin
                        idx_d   = scan[IDX_W-1:0];
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout_hit) begin
                    // Remaining children are abandoned.
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decode registered state only.
    assign child_start_o = (state_q == S_ISSUE)
                         ? ({{(NUM_CHILD-1){1'b0}}, 1'b1} << idx_q)
                         : '0;
    assign cur_idx_o     = idx_q;
    assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_subtree_child_sequencer.sv
// -----------------------------------------------------------------------------
// tb_subtree_child_sequencer
//
// The stimulus process plays both the parent (start_i, skip mask, reset) and
// the five children (done strobes after a random latency). From the run rules
// alone it predicts, cycle by cycle, what the sequencer must show and pushes
// those expectations into a scoreboard queue. The monitor process checks the
// outputs on every falling edge against the queue and flags any output event
// that was not predicted.
// -----------------------------------------------------------------------------
module tb_subtree_child_sequencer;

    localparam int NC  = 5;
    localparam int TO  = 8;
    localparam int WDG = 20000;

    localparam int K_START = 0;   // child_start_o strobe expected this cycle
    localparam int K_DONE  = 1;   // done_o pulse expected this cycle
    localparam int K_PROBE = 2;   // quiet cycle: busy/err as given, no strobes
    localparam int K_RESET = 3;   // every output at its reset value

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [NC-1:0] skip_mask_i;
    logic [NC-1:0] child_start_o;
    logic [NC-1:0] child_done_i;
    logic [2:0]    cur_idx_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    subtree_child_sequencer #(
        .NUM_CHILD     (NC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .skip_mask_i  (skip_mask_i),
        .child_start_o(child_start_o),
        .child_done_i (child_done_i),
        .cur_idx_o    (cur_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int idx;
        bit busy;
        bit err;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    bit   stim_done = 1'b0;

    // Reference state owned by the stimulus process.
    int   last_idx = 0;
    bit   exp_err  = 1'b0;

    task automatic push(input int c, input int k, input int i, input bit b, input bit e);
        exp_t x;
        x.cyc  = c;
        x.kind = k;
        x.idx  = i;
        x.busy = b;
        x.err  = e;
        q.push_back(x);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    bit   got_s;
    bit   got_d;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            got_s = 1'b0;
            got_d = 1'b0;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e = q.pop_front();
                if (mon_e.cyc < cyc) begin
                    chk("late_expectation", mon_e.cyc, cyc);
                    continue;
                end
                case (mon_e.kind)
                    K_START: begin
                        got_s = 1'b1;
                        chk("start_vec", int'(child_start_o), 1 << mon_e.idx);
                        chk("start_cur_idx", int'(cur_idx_o), mon_e.idx);
                        chk("start_busy", int'(busy_o), 1);
                        chk("start_err", int'(err_o), int'(mon_e.err));
                        chk("start_no_done", int'(done_o), 0);
                    end
                    K_DONE: begin
                        got_d = 1'b1;
                        chk("done_pulse", int'(done_o), 1);
                        chk("done_err", int'(err_o), int'(mon_e.err));
                        chk("done_busy", int'(busy_o), 0);
                        chk("done_cur_idx", int'(cur_idx_o), mon_e.idx);
                        chk("done_no_start", int'(child_start_o), 0);
                    end
                    K_PROBE: begin
                        chk("probe_busy", int'(busy_o), int'(mon_e.busy));
                        chk("probe_err", int'(err_o), int'(mon_e.err));
                        chk("probe_no_start", int'(child_start_o), 0);
                        chk("probe_no_done", int'(done_o), 0);
                    end
                    default: begin
                        chk("reset_start", int'(child_start_o), 0);
                        chk("reset_cur_idx", int'(cur_idx_o), 0);
                        chk("reset_busy", int'(busy_o), 0);
                        chk("reset_done", int'(done_o), 0);
                        chk("reset_err", int'(err_o), 0);
                    end
                endcase
            end
            if (child_start_o != '0 && !got_s) chk("unexpected_start", int'(child_start_o), 0);
            if (done_o && !got_d) chk("unexpected_done", int'(done_o), 0);
            if (stim_done || cyc > WDG) begin
                chk("scoreboard_drained", q.size(), 0);
                chk("watchdog", int'(cyc > WDG), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_i      = 1'b0;
            child_done_i = '0;
            skip_mask_i  = 5'($urandom);
            push(cyc + 1, K_PROBE, 0, 1'b0, exp_err);
        end
    endtask

    // One run. noise: random skip_mask_i changes, start_i held high and stray
    // dones from other children (bit 4 always, unless child 4 is active)
    // while a child is running, plus a possibly-lost done in the ISSUE cycle.
    // rst_child: assert rst in the first WAIT cycle of that child.
    // silent: that child never answers (only meaningful with the timeout).
    task automatic do_run(input logic [NC-1:0] mask, input int dmin, input int dmax,
                          input bit noise, input int rst_child, input int silent);
        int list[$];
        int idx;
        int d;
        bit abandoned;
        abandoned = 1'b0;
        @(negedge clk);
        start_i      = 1'b1;
        skip_mask_i  = mask;
        child_done_i = '0;
        exp_err      = 1'b0;
        for (int i = 0; i < NC; i++) if (!mask[i]) list.push_back(i);
        if (list.size() == 0) push(cyc + 1, K_DONE, last_idx, 1'b0, 1'b0);
        else                  push(cyc + 1, K_START, list[0], 1'b1, 1'b0);
        for (int k = 0; k < list.size() && !abandoned; k++) begin
            idx = list[k];
            @(negedge clk);                               // ISSUE cycle
            last_idx     = idx;
            start_i      = noise ? 1'($urandom) : 1'b0;
            skip_mask_i  = 5'($urandom);
            child_done_i = noise ? 5'($urandom) : '0;     // a done here is lost
            d = (idx == silent) ? TO : dmin + int'($urandom % 32'(dmax - dmin + 1));
            push(cyc + 1, K_PROBE, 0, 1'b1, 1'b0);
            for (int j = 1; j <= d; j++) begin
                @(negedge clk);                           // WAIT cycle j
                start_i = noise;
                if (idx == rst_child && j == 1) begin
                    rst          = 1'b1;
                    start_i      = 1'b0;
                    child_done_i = '0;
                    last_idx     = 0;
                    exp_err      = 1'b0;
                    push(cyc + 1, K_RESET, 0, 1'b0, 1'b0);
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (j < d) begin
                    child_done_i = noise ? ((5'($urandom) | 5'b10000) & ~(5'(1) << idx)) : '0;
                    push(cyc + 1, K_PROBE, 0, 1'b1, 1'b0);
                end else if (idx == silent) begin
                    child_done_i = '0;
                    exp_err      = 1'b1;
                    abandoned    = 1'b1;
                    push(cyc + 1, K_DONE, idx, 1'b0, 1'b1);
                end else begin
                    child_done_i = (5'(1) << idx) | (noise ? 5'($urandom) : 5'b0);
                    if (k + 1 < list.size()) push(cyc + 1, K_START, list[k+1], 1'b1, 1'b0);
                    else                     push(cyc + 1, K_DONE, idx, 1'b0, 1'b0);
                end
            end
        end
        @(negedge clk);                                   // DONE cycle
        start_i      = noise;                             // ignored in DONE
        child_done_i = noise ? 5'($urandom) : '0;
        push(cyc + 1, K_PROBE, 0, 1'b0, exp_err);
    endtask

    initial begin : stimulus
        logic [NC-1:0] m;
        rst          = 1'b1;
        start_i      = 1'b0;
        skip_mask_i  = '0;
        child_done_i = '0;
        push(2, K_RESET, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(cyc + 1, K_PROBE, 0, 1'b0, 1'b0);

        do_run(5'b00000, 3, 3, 1'b0, -1, -1);   // every child, fixed 3-cycle latency
        do_run(5'b10101, 1, 4, 1'b0, -1, -1);   // only children 1 and 3
        do_run(5'b11111, 1, 1, 1'b0, -1, -1);   // all skipped
        do_run(5'b00000, 2, 4, 1'b1, -1, -1);   // strays and held start_i
        do_run(5'b00000, 2, 3, 1'b0,  2, -1);   // reset while waiting on child 2
        do_run(5'b00000, 1, 2, 1'b0, -1, -1);   // fresh run from child 0
        idle(2);
`ifdef SCHED_TIMEOUT_EN
        do_run(5'b11100, 1, 1, 1'b0, -1,  0);   // child 0 silent -> timeout
        idle(2);                                // err_o stays set
        do_run(5'b11110, 1, 2, 1'b0, -1, -1);   // next start clears it
`endif
        for (int r = 0; r < 40; r++) begin
            m = 5'($urandom);
            if ($urandom % 8 == 0) m = 5'b11111;
            if ($urandom % 8 == 0) m = 5'b00000;
            do_run(m, 1, 5, 1'($urandom), ($urandom % 10 == 0) ? int'($urandom % NC) : -1, -1);
            idle(int'($urandom % 3));
        end
        idle(2);
        @(negedge clk);
        stim_done = 1'b1;
    end

endmodule
